// File: rtl/wb_gpio_arbiter_if.sv
// Wishbone link bundle shared by the two master ports and the GPIO slave port.
// The arbiter takes the slave modport on each master link and the master
// modport on the link to the GPIO peripheral.
interface wb_gpio_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    // Master side: the GPIO peripheral has no error output, so err is not read here
    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_gpio_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the GPIO peripheral.
// The grant is held for the owner's whole cycle. A watchdog ends stalled
// strobes with a one-cycle error pulse so a hung slave cannot lock a master.
module wb_gpio_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    wb_gpio_arbiter_if.slave        m0,
    wb_gpio_arbiter_if.slave        m1,
    wb_gpio_arbiter_if.master       s,
    output logic [1:0]              gnt_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic             owner, owner_nx;
    logic             last, last_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic busy;
    logic own_cyc;
    logic own_stb;
    logic timeout;
    logic own_ack;

    // Owner-side view of the request and the watchdog expiry condition
    always_comb begin
        busy    = (state == BUSY);
        own_cyc = owner ? m1.cyc : m0.cyc;
        own_stb = owner ? m1.stb : m0.stb;
        timeout = busy && own_cyc && own_stb && !s.ack
                  && (cnt == CNT_W'(TIMEOUT - 1));
        own_ack = s.ack && busy && own_cyc;
    end

    // State register; last starts at m1 so m0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: grant in IDLE, release on owner cyc low, advance the watchdog
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = '0;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_nx = BUSY;
                    owner_nx = ~last;
                    last_nx  = ~last;
                end else if (m0.cyc) begin
                    state_nx = BUSY;
                    owner_nx = 1'b0;
                    last_nx  = 1'b0;
                end else if (m1.cyc) begin
                    state_nx = BUSY;
                    owner_nx = 1'b1;
                    last_nx  = 1'b1;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_nx = IDLE;
                end else if (own_stb && !s.ack && !timeout) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: slave bus muxed from the owner, responses routed back to it
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.sel   = '0;
        s.dat_w = '0;
        if (busy) begin
            s.cyc   = own_cyc;
            s.stb   = own_stb && !timeout;
            s.we    = owner ? m1.we    : m0.we;
            s.adr   = owner ? m1.adr   : m0.adr;
            s.sel   = owner ? m1.sel   : m0.sel;
            s.dat_w = owner ? m1.dat_w : m0.dat_w;
        end
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
        m0.ack   = own_ack && !owner;
        m1.ack   = own_ack && owner;
        m0.err   = timeout && !owner;
        m1.err   = timeout && owner;
        gnt_o    = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Directed bench for wb_gpio_arbiter with a small GPIO slave model:
// 0x10 reads gpio_in, 0x14 is a read/write register, ack one cycle after strobe.
module tb_wb_gpio_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_gpio_arbiter_if m0_bus ();
    wb_gpio_arbiter_if m1_bus ();
    wb_gpio_arbiter_if s_bus ();
    logic [1:0] gnt;

    wb_gpio_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .gnt_o (gnt)
    );

    int total = 0;
    int bad   = 0;

    // GPIO slave model
    logic        ack_auto = 1'b1;
    logic        ack_man  = 1'b0;
    logic        ack_r    = 1'b0;
    logic [31:0] gpio_in  = 32'hA5A5_0001;
    logic [31:0] reg14    = 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= s_bus.stb && !ack_r;
            if (s_bus.stb && !ack_r && s_bus.we && s_bus.adr == 32'h14)
                reg14 <= s_bus.dat_w;
        end
    end

    assign s_bus.ack   = ack_auto ? ack_r : ack_man;
    assign s_bus.dat_r = (s_bus.adr == 32'h10) ? gpio_in :
                         (s_bus.adr == 32'h14) ? reg14 : 32'h0;
    assign s_bus.err   = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int unsigned m, input logic cyc, input logic stb,
                         input logic we, input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.adr = adr; m0_bus.sel = 4'hF; m0_bus.dat_w = dat;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.adr = adr; m1_bus.sel = 4'hF; m1_bus.dat_w = dat;
        end
        #1;
    endtask

    // Advance until master m sees ack or err, bounded by max cycles
    task automatic wait_resp(input int unsigned m, input int unsigned max,
                             output int unsigned cycles, output logic ack,
                             output logic err, output logic [31:0] data,
                             output logic other_ack);
        ack = 1'b0; err = 1'b0; data = '0; other_ack = 1'b0; cycles = 0;
        for (int i = 0; i < int'(max) && !ack && !err; i++) begin
            tick();
            cycles++;
            if (m == 0) begin
                ack = m0_bus.ack; err = m0_bus.err; data = m0_bus.dat_r;
                if (m1_bus.ack) other_ack = 1'b1;
            end else begin
                ack = m1_bus.ack; err = m1_bus.err; data = m1_bus.dat_r;
                if (m0_bus.ack) other_ack = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick(); tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        total++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin bad++; $display("FAIL reset_sbus: cyc=%b stb=%b want 0 0", s_bus.cyc, s_bus.stb); end
        total++; if ({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err} !== 4'b0000) begin bad++; $display("FAIL reset_resp: got %b want 0000", {m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int unsigned n; logic a, e, o; logic [31:0] d;
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL sr_pre_gnt: got %b want 00", gnt); end
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL sr_gnt: got %b want 01", gnt); end
        total++; if (s_bus.stb !== 1'b1 || s_bus.adr !== 32'h10) begin bad++; $display("FAIL sr_sbus: stb=%b adr=%h want 1 10", s_bus.stb, s_bus.adr); end
        wait_resp(0, 10, n, a, e, d, o);
        total++; if (a !== 1'b1 || n != 1) begin bad++; $display("FAIL sr_ack: ack=%b cycles=%0d want 1 1", a, n); end
        total++; if (d !== 32'hA5A5_0001) begin bad++; $display("FAIL sr_data: got %h want a5a50001", d); end
        total++; if (o !== 1'b0 || m1_bus.ack !== 1'b0) begin bad++; $display("FAIL sr_m1_ack: got %b want 0", o | m1_bus.ack); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL sr_release: got %b want 00", gnt); end
    endtask

    task automatic test_round_robin();
        int unsigned n; logic a, e, o; logic [31:0] d;
        reset = 1'b1; tick(); reset = 1'b0;
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        set_m(1, 1, 1, 0, 32'h14, 32'h0);
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rr_first: got %b want 01", gnt); end
        wait_resp(0, 10, n, a, e, d, o);
        total++; if (a !== 1'b1 || o !== 1'b0) begin bad++; $display("FAIL rr_m0_ack: ack=%b m1ack=%b want 1 0", a, o); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rr_idle_gap: got %b want 00", gnt); end
        tick();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rr_second: got %b want 10", gnt); end
        wait_resp(1, 10, n, a, e, d, o);
        total++; if (a !== 1'b1 || d !== reg14) begin bad++; $display("FAIL rr_m1_ack: ack=%b data=%h want 1 %h", a, d, reg14); end
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        set_m(1, 1, 1, 0, 32'h10, 32'h0);
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rr_third: got %b want 01", gnt); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick(); tick();
    endtask

    task automatic test_hold_grant();
        int unsigned n; logic a, e, o; logic [31:0] d;
        // last is m0, so m1 wins this tie
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        set_m(1, 1, 1, 1, 32'h14, 32'h0000_00FF);
        tick();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL hold_gnt: got %b want 10", gnt); end
        wait_resp(1, 10, n, a, e, d, o);
        total++; if (a !== 1'b1 || o !== 1'b0) begin bad++; $display("FAIL hold_wr_ack: ack=%b m0ack=%b want 1 0", a, o); end
        set_m(1, 1, 0, 0, 32'h14, 32'h0);
        tick();
        total++; if (gnt !== 2'b10 || s_bus.stb !== 1'b0) begin bad++; $display("FAIL hold_gap: gnt=%b stb=%b want 10 0", gnt, s_bus.stb); end
        set_m(1, 1, 1, 0, 32'h14, 32'h0);
        wait_resp(1, 10, n, a, e, d, o);
        total++; if (a !== 1'b1 || d !== 32'h0000_00FF) begin bad++; $display("FAIL hold_rd: ack=%b data=%h want 1 000000ff", a, d); end
        total++; if (o !== 1'b0 || gnt !== 2'b10) begin bad++; $display("FAIL hold_m0_stall: m0ack=%b gnt=%b want 0 10", o, gnt); end
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL hold_release: got %b want 00", gnt); end
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL hold_m0_gnt: got %b want 01", gnt); end
        wait_resp(0, 10, n, a, e, d, o);
        total++; if (a !== 1'b1 || d !== 32'hA5A5_0001) begin bad++; $display("FAIL hold_m0_rd: ack=%b data=%h want 1 a5a50001", a, d); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_timeout();
        int unsigned errs;
        ack_auto = 1'b0; ack_man = 1'b0;
        errs = 0;
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) tick();
            if (i < 16) begin
                if (m0_bus.err) errs++;
                total++; if (s_bus.stb !== 1'b1) begin bad++; $display("FAIL to_stb_cycle%0d: got %b want 1", i, s_bus.stb); end
            end else begin
                total++; if (m0_bus.err !== 1'b1) begin bad++; $display("FAIL to_err16: got %b want 1", m0_bus.err); end
                total++; if (s_bus.stb !== 1'b0 || m0_bus.ack !== 1'b0) begin bad++; $display("FAIL to_stb_ack16: stb=%b ack=%b want 0 0", s_bus.stb, m0_bus.ack); end
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL to_early_err: got %0d want 0", errs); end
        tick();
        total++; if (m0_bus.err !== 1'b0 || s_bus.stb !== 1'b1) begin bad++; $display("FAIL to_err_pulse: err=%b stb=%b want 0 1", m0_bus.err, s_bus.stb); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_ack_at_limit();
        int unsigned n;
        ack_auto = 1'b0; ack_man = 1'b0;
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        tick();
        for (int i = 2; i <= 16; i++) tick();
        ack_man = 1'b1;
        #1;
        total++; if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0) begin bad++; $display("FAIL lim_ack: ack=%b err=%b want 1 0", m0_bus.ack, m0_bus.err); end
        total++; if (s_bus.stb !== 1'b1) begin bad++; $display("FAIL lim_stb: got %b want 1", s_bus.stb); end
        tick();
        ack_man = 1'b0;
        #1;
        // The counter restarted from zero, so err lands on the 16th cycle again
        n = 1;
        while (!m0_bus.err && n < 40) begin
            tick();
            n++;
        end
        total++; if (n != 16) begin bad++; $display("FAIL lim_cnt_clear: err after %0d cycles want 16", n); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        ack_auto = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        set_m(1, 1, 1, 0, 32'h10, 32'h0);
        tick();
        total++; if (gnt !== 2'b10 || s_bus.stb !== 1'b1) begin bad++; $display("FAIL rm_owner: gnt=%b stb=%b want 10 1", gnt, s_bus.stb); end
        reset = 1'b1;
        tick();
        total++; if (gnt !== 2'b00 || s_bus.stb !== 1'b0 || s_bus.cyc !== 1'b0) begin bad++; $display("FAIL rm_reset: gnt=%b stb=%b cyc=%b want 00 0 0", gnt, s_bus.stb, s_bus.cyc); end
        reset = 1'b0;
        set_m(0, 1, 1, 0, 32'h10, 32'h0);
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_after: got %b want 01", gnt); end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold_grant();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wb_gpio_arbiter.md
Name: wb_gpio_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the GPIO peripheral between the LM32 data bus (m0) and a secondary master (m1, debug/DMA).
- Round-robin grant, held for the owner's whole cycle (cyc high), so multi-access sequences stay atomic.
- Bus-timeout watchdog terminates stalled accesses with an error pulse so a hung slave cannot lock up either master.
- Sits between the two master ports and the GPIO slave's Wishbone interface.

Parameters:
- TIMEOUT, 16: cycles an owner's strobe may wait for s_ack before err is signalled (legal range 2..255).
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
- m0_adr_i  in  32  master 0 address
- m0_sel_i  in  4  master 0 byte select
- m0_dat_i  in  32  master 0 write data
- m0_dat_o  out  32  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  master 0 ack / timeout error
- m1_*  (same set as m0)  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  32  to slave
- s_sel_o  out  4  to slave
- s_dat_o  out  32  write data to slave
- s_dat_i  in  32  read data from slave
- s_ack_i  in  1  slave ack
- gnt_o  out  2  one-hot current owner (status/debug)

Behaviour:
- State: busy (1b), owner (1b), last (1b, last master granted), cnt (CNT_W).
- Reset: busy=0, owner=0, last=1 (m0 wins first tie), cnt=0.
- Outputs at reset: gnt_o=00, all s_* control=0, all m*_ack_o/m*_err_o=0.
- IDLE (busy=0):
  - s_cyc_o=s_stb_o=0.
  - At the clock edge, if any mN_cyc_i is high, grant it: busy<=1, owner<=N, last<=N.
  - Both requesting: grant the master != last.
- Grant latency: request visible at edge k; s_cyc_o/s_stb_o driven from that owner in the cycle after edge k.
- BUSY:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o and s_dat_o are combinationally muxed from the owner.
  - s_stb_o is forced 0 in the cycle err is asserted.
- Release: at the first edge where the owner's cyc_i is low, busy<=0.
  - A new grant can be made at the next edge; there is one idle bus cycle between owners.
  - The same master re-requesting competes under round-robin.
- Response routing:
  - owner ack_o = s_ack_i & busy & owner cyc_i; non-owner ack_o = 0.
  - Both mN_dat_o = s_dat_i, valid only when that master's ack_o is asserted.
- Non-owner cyc/stb is ignored (stalled, no ack) until granted.
- Timeout:
  - cnt increments each BUSY cycle with owner stb_i high and s_ack_i low.
  - cnt clears on s_ack_i, on owner stb_i low, or on err.
  - When cnt == TIMEOUT-1 and s_ack_i is low, owner err_o=1 for exactly one cycle, ack_o=0, and cnt clears.
  - s_ack_i and the timeout in the same cycle: ack wins, no err.
- Owner drops cyc mid-access without ack: the access is abandoned, release follows the normal rule, no err.
- Reset asserted mid-transaction: return to the reset state at that edge. Outputs go to their reset values the following cycle.
- gnt_o = busy ? (owner ? 10 : 01) : 00.

Test Plan:
- Single m0 read of 0x10 with gpio_in=0xA5A5_0001 -> gnt_o=01 one cycle after cyc, m0_ack_o pulses with m0_dat_o=0xA5A5_0001, m1_ack_o stays 0.
- m0 and m1 assert cyc on the same edge after reset -> m0 granted first. m1 is granted after m0 drops cyc plus one idle cycle. The next simultaneous request goes to m0 again (last=1).
- m1 holds cyc, writes 0x14=0x0000_00FF then reads 0x14 while m0 requests -> m1 keeps the grant for both, reads 0x0000_00FF, m0 gets no ack until m1 releases.
- Slave tied s_ack_i=0, m0 strobes with TIMEOUT=16 -> m0_err_o high for exactly one cycle at the 16th strobe cycle, s_stb_o low that cycle, no ack.
- s_ack_i asserted exactly on the cycle cnt==TIMEOUT-1 -> ack delivered, err stays 0, cnt=0.
- reset pulsed while m1 is owner mid-strobe -> next cycle gnt_o=00, s_stb_o=0. With both requesting after reset, m0 is granted.
